// File: rtl/encoder8x3_seq_if.sv
// Request/index bus between a request encoder and its consumer.
// Master drives capture enable, request pulses and acknowledge.
// Slave (the encoder) returns the index, valid, pending vector and miss pulse.
interface encoder8x3_seq_if #(
    parameter int W = 8
);
    localparam int AW = $clog2(W);

    logic          E;
    logic [W-1:0]  D;
    logic          ACK;
    logic [AW-1:0] Y;
    logic          V;
    logic [W-1:0]  PEND;
    logic          MISS;

    modport master (
        output E, D, ACK,
        input  Y, V, PEND, MISS
    );

    modport slave (
        input  E, D, ACK,
        output Y, V, PEND, MISS
    );
endinterface

// File: rtl/encoder8x3_seq.sv
// Registered W-to-log2(W) request encoder with pending capture and valid/ack handshake.
// Request pulses on D collect in a pending register. One pending index at a time is
// presented on Y with V. The index is held until it is acknowledged, and the acknowledge
// clears that pending bit.
// Build option: define ENC_RR_EN for round-robin selection. Without it, the highest
// pending index always wins.
module encoder8x3_seq #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    encoder8x3_seq_if.slave   bus
);
    localparam int AW = $clog2(W);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0]    r_state;
    logic [W-1:0]  r_pend;
    logic [AW-1:0] r_y;
    logic          r_v;
    logic          r_miss;

    logic [W-1:0]  w_set_mask;
    logic [W-1:0]  w_clr_mask;
    logic          w_ack;
    logic [AW-1:0] w_sel;

`ifdef ENC_RR_EN
    logic [AW-1:0] r_rr_ptr;

    // Round-robin pick: the first set bit at or after ptr+1, ascending with wrap.
    // The loop runs from the farthest offset back to the nearest offset. The nearest hit
    // is assigned last, so it wins.
    function automatic logic [AW-1:0] sel_rr(input logic [W-1:0] p, input logic [AW-1:0] ptr);
        logic [AW-1:0] s;
        logic [AW-1:0] cand;
        s = '0;
        for (int k = W - 1; k >= 0; k--) begin
            cand = ptr + AW'(1) + AW'(k);
            if (p[cand]) s = cand;
        end
        return s;
    endfunction
`else
    // Fixed priority pick: the highest set index wins.
    function automatic logic [AW-1:0] sel_fixed(input logic [W-1:0] p);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            if (p[i]) s = AW'(i);
        end
        return s;
    endfunction
`endif

    // Build the capture and clear masks, and select the next index from the registered pending bits.
    always_comb begin
        w_set_mask = bus.E ? bus.D : '0;
        w_ack      = r_v & bus.ACK;
        w_clr_mask = '0;
        if (w_ack) w_clr_mask[r_y] = 1'b1;
`ifdef ENC_RR_EN
        w_sel = sel_rr(r_pend, r_rr_ptr);
`else
        w_sel = sel_fixed(r_pend);
`endif
    end

    // Update the pending register. Set wins over clear, and a capture that lands on a bit
    // that stays pending raises MISS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_miss <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
            r_miss <= |(w_set_mask & r_pend & ~w_clr_mask);
        end
    end

    // Presentation FSM. IDLE latches a pending index. PRESENT holds it until ACK, then
    // returns to IDLE for one bubble cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend != '0) begin
                        r_y     <= w_sel;
                        r_v     <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.ACK) begin
                        r_v     <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_v     <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ENC_RR_EN
    // Remember the last acknowledged index, so the next search starts just above it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= AW'(W - 1);
        end else if (w_ack) begin
            r_rr_ptr <= r_y;
        end
    end
`endif

    assign bus.Y    = r_y;
    assign bus.V    = r_v;
    assign bus.PEND = r_pend;
    assign bus.MISS = r_miss;
endmodule

// File: tb/tb_encoder8x3_seq.sv
// Testbench for encoder8x3_seq.
// A directed sequence is followed by random requests. Both are checked every cycle
// against an abstract cycle model. The model uses the round-robin rules when ENC_RR_EN
// is defined.
module tb_encoder8x3_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    encoder8x3_seq_if #(.W(W)) bus ();

    encoder8x3_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abstract model state.
    int m_pend;
    int m_y;
    int m_v;
    int m_miss;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_fixed(input int p);
        for (int i = W - 1; i >= 0; i--)
            if (((p >> i) & 1) != 0) return i;
        return 0;
    endfunction

    function automatic int pick_rr(input int p, input int ptr);
        for (int d = 1; d <= W; d++) begin
            int c;
            c = (ptr + d) % W;
            if (((p >> c) & 1) != 0) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = 0;
        m_y    = 0;
        m_v    = 0;
        m_miss = 0;
        m_ptr  = W - 1;
    endtask

    task automatic model_edge(input int e, input int d, input int ack);
        int set_m, clr_m, acc;
        set_m = (e != 0) ? d : 0;
        acc   = (m_v != 0 && ack != 0) ? 1 : 0;
        clr_m = (acc != 0) ? (1 << m_y) : 0;
        m_miss = ((set_m & m_pend & ~clr_m) != 0) ? 1 : 0;
        if (m_v == 0) begin
            if (m_pend != 0) begin
`ifdef ENC_RR_EN
                m_y = pick_rr(m_pend, m_ptr);
`else
                m_y = pick_fixed(m_pend);
`endif
                m_v = 1;
            end
        end else if (ack != 0) begin
            m_v   = 0;
            m_ptr = m_y;
        end
        m_pend = ((m_pend & ~clr_m) | set_m) & ((1 << W) - 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Y"},    32'(bus.Y),    32'(m_y));
        chk({tag, ".V"},    32'(bus.V),    32'(m_v));
        chk({tag, ".PEND"}, 32'(bus.PEND), 32'(m_pend));
        chk({tag, ".MISS"}, 32'(bus.MISS), 32'(m_miss));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then compare 1 time unit later.
    task automatic step(input string tag, input logic e, input logic [W-1:0] d, input logic ack);
        bus.E   = e;
        bus.D   = d;
        bus.ACK = ack;
        @(posedge clk);
        model_edge(int'(e), int'(d), int'(ack));
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        bus.E   = 1'b0;
        bus.D   = '0;
        bus.ACK = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.E = 1'b0;
        bus.D = '0;
        bus.ACK = 1'b0;
        model_reset();
        #2;
        do_reset();

        // 1: idle with no requests
        for (int i = 0; i < 10; i++) step("t1", 1'b1, 8'h00, 1'b0);
        chk("t1_v", 32'(bus.V), 32'd0);

        // 2: single request, then acknowledge
        step("t2a", 1'b1, 8'h08, 1'b0);
        chk("t2_pend", 32'(bus.PEND), 32'h08);
        step("t2b", 1'b1, 8'h00, 1'b0);
        chk("t2_v", 32'(bus.V), 32'd1);
        chk("t2_y", 32'(bus.Y), 32'd3);
        step("t2c", 1'b1, 8'h00, 1'b1);
        chk("t2_pend0", 32'(bus.PEND), 32'h00);
        chk("t2_v0", 32'(bus.V), 32'd0);

        // 3: two simultaneous requests with ACK held high
        do_reset();
        step("t3a", 1'b1, 8'h81, 1'b1);
        step("t3b", 1'b1, 8'h00, 1'b1);
`ifdef ENC_RR_EN
        chk("t3_y1", 32'(bus.Y), 32'd0);
`else
        chk("t3_y1", 32'(bus.Y), 32'd7);
`endif
        step("t3c", 1'b1, 8'h00, 1'b1);
        chk("t3_bubble", 32'(bus.V), 32'd0);
        step("t3d", 1'b1, 8'h00, 1'b1);
`ifdef ENC_RR_EN
        chk("t3_y2", 32'(bus.Y), 32'd7);
`else
        chk("t3_y2", 32'(bus.Y), 32'd0);
`endif
        step("t3e", 1'b1, 8'h00, 1'b1);
        chk("t3_pend", 32'(bus.PEND), 32'h00);

        // 4: miss on an already pending bit; E=0 blocks capture
        step("t4a", 1'b1, 8'h04, 1'b0);
        step("t4b", 1'b1, 8'h00, 1'b0);
        step("t4c", 1'b1, 8'h04, 1'b0);
        chk("t4_miss", 32'(bus.MISS), 32'd1);
        chk("t4_pend", 32'(bus.PEND), 32'h04);
        step("t4d", 1'b1, 8'h00, 1'b0);
        chk("t4_miss0", 32'(bus.MISS), 32'd0);
        step("t4e", 1'b0, 8'hFF, 1'b0);
        chk("t4_pend_e0", 32'(bus.PEND), 32'h04);

        // 5: re-request of the presented bit during its acknowledge
        chk("t5_pre_y", 32'(bus.Y), 32'd2);
        step("t5a", 1'b1, 8'h04, 1'b1);
        chk("t5_pend", 32'(bus.PEND), 32'h04);
        step("t5b", 1'b1, 8'h00, 1'b0);
        chk("t5_v", 32'(bus.V), 32'd1);
        chk("t5_y", 32'(bus.Y), 32'd2);
        step("t5c", 1'b1, 8'h00, 1'b1);

        // 6: asynchronous reset while presenting
        step("t6a", 1'b1, 8'h40, 1'b0);
        step("t6b", 1'b1, 8'h00, 1'b0);
        chk("t6_y", 32'(bus.Y), 32'd6);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("t6_post", 1'b1, 8'h00, 1'b0);

        // Random traffic: sparse requests, random enable and acknowledge
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] rd;
            logic         re, ra;
            rd = W'($urandom & $urandom & $urandom);
            re = ($urandom_range(0, 9) < 8);
            ra = ($urandom_range(0, 2) != 0);
            step("rnd", re, rd, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
